// File: rtl/plic_claim_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : plic_claim_arbiter
// Purpose  : Per-target PLIC gateway, serial priority scan and claim/complete
//            sequencer. Define PLIC_EDGE_TRIGGER_EN for edge-triggered gateways.
// Revision : 1.0 - initial release
// ============================================================================
module plic_claim_arbiter #(
  parameter int INTERRUPTS      = 8,
  parameter int PRIORITY_LEVELS = 32,
  parameter int PRIO_W          = $clog2(PRIORITY_LEVELS),
  parameter int ID_W            = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       global_interrupts,
  input  logic              prio_wr_en,
  input  logic [ID_W-1:0]   prio_wr_id,
  input  logic [PRIO_W-1:0] prio_wr_data,
  input  logic [31:0]       enable_mask,
  input  logic [PRIO_W-1:0] threshold,
  input  logic              claim_req,
  output logic              claim_valid,
  output logic [ID_W-1:0]   claim_id,
  input  logic              complete_req,
  input  logic [ID_W-1:0]   complete_id,
  output logic [31:0]       interrupt_pending,
  output logic              irq_out
);

  // Bits 1..INTERRUPTS are real sources; bit 0 is the "no interrupt" ID.
  localparam logic [31:0]     c_src_mask = 32'((64'h1 << (INTERRUPTS + 1)) - 64'h1) & ~32'h1;
  localparam logic [ID_W-1:0] c_last_id  = ID_W'(INTERRUPTS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [PRIO_W-1:0] r_prio [1:INTERRUPTS];
  logic [31:0]       r_pending;
  logic [31:0]       r_in_flight;
  logic [ID_W-1:0]   r_scan_id;
  logic [ID_W-1:0]   r_best_id;
  logic [PRIO_W-1:0] r_best_prio;
  logic [ID_W-1:0]   r_win_id;
  logic              r_irq;
  logic              r_claim_valid;
  logic [ID_W-1:0]   r_claim_id;

  logic [31:0]       w_lines;
  logic [31:0]       w_complete_mask;
  logic [31:0]       w_in_flight_eff;
  logic [31:0]       w_set;
  logic [31:0]       w_claim_mask;
  logic [PRIO_W-1:0] w_scan_prio;
  logic [PRIO_W-1:0] w_win_prio;
  logic              w_scan_hit;
  logic              w_claim_ok;
  logic              w_scan_restart;
  logic              w_best_load;
  logic              w_publish;

  // --------------------------------------------------------------------------
  // Priority registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= INTERRUPTS; i++) r_prio[i] <= '0;
    end else if (prio_wr_en) begin
      for (int i = 1; i <= INTERRUPTS; i++) begin
        if (prio_wr_id == ID_W'(i)) r_prio[i] <= prio_wr_data;
      end
    end
  end

  always_comb begin
    w_scan_prio = '0;
    w_win_prio  = '0;
    for (int i = 1; i <= INTERRUPTS; i++) begin
      if (r_scan_id == ID_W'(i)) w_scan_prio = r_prio[i];
      if (r_win_id  == ID_W'(i)) w_win_prio  = r_prio[i];
    end
  end

  // --------------------------------------------------------------------------
  // Gateway: pending / in-flight bookkeeping
  // --------------------------------------------------------------------------
  assign w_lines = global_interrupts & c_src_mask;

  // Out-of-range or non-in-flight completions fall out of the mask naturally.
  assign w_complete_mask = complete_req ? ((32'h1 << complete_id) & c_src_mask & r_in_flight)
                                        : 32'h0;
  assign w_in_flight_eff = r_in_flight & ~w_complete_mask;

  assign w_claim_ok = claim_req && (r_win_id != '0) && r_pending[r_win_id] &&
                      enable_mask[r_win_id] && (w_win_prio > threshold);
  assign w_claim_mask = w_claim_ok ? (32'h1 << r_win_id) : 32'h0;

`ifdef PLIC_EDGE_TRIGGER_EN
  logic [31:0] r_line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_line_q <= '0;
    else        r_line_q <= w_lines;
  end

  assign w_set = w_lines & ~r_line_q & ~w_in_flight_eff;
`else
  assign w_set = w_lines & ~w_in_flight_eff;
`endif

  // Claim clears after set so that a same-cycle set/claim leaves pending low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_in_flight <= '0;
    end else begin
      r_pending   <= (r_pending | w_set) & ~w_claim_mask;
      r_in_flight <= w_in_flight_eff | w_claim_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  assign w_scan_hit = r_pending[r_scan_id] && enable_mask[r_scan_id] &&
                      (w_scan_prio > threshold) && (w_scan_prio > r_best_prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_scan_restart = 1'b0;
    w_best_load    = 1'b0;
    w_publish      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_SCAN;
        w_scan_restart = 1'b1;
      end
      S_SCAN: begin
        if (w_claim_ok) begin
          w_scan_restart = 1'b1;
        end else begin
          w_best_load = w_scan_hit;
          if (r_scan_id == c_last_id) w_state_nxt = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        w_state_nxt    = S_SCAN;
        w_scan_restart = 1'b1;
        w_publish      = !w_claim_ok;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_id     <= '0;
      r_best_id     <= '0;
      r_best_prio   <= '0;
      r_win_id      <= '0;
      r_irq         <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else begin
      r_claim_valid <= claim_req;
      r_claim_id    <= w_claim_ok ? r_win_id : '0;

      if (w_scan_restart) begin
        r_scan_id   <= ID_W'(1);
        r_best_id   <= '0;
        r_best_prio <= '0;
      end else begin
        if (r_state == S_SCAN) r_scan_id <= r_scan_id + ID_W'(1);
        if (w_best_load) begin
          r_best_id   <= r_scan_id;
          r_best_prio <= w_scan_prio;
        end
      end

      // A successful claim retires the published winner immediately.
      if (w_claim_ok) begin
        r_win_id <= '0;
        r_irq    <= 1'b0;
      end else if (w_publish) begin
        r_win_id <= r_best_id;
        r_irq    <= (r_best_id != '0);
      end
    end
  end

  assign claim_valid       = r_claim_valid;
  assign claim_id          = r_claim_id;
  assign interrupt_pending = r_pending;
  assign irq_out           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_plic_claim_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_claim_arbiter
// Purpose  : Self-checking bench for plic_claim_arbiter (vector table, hand
//            sequences and randomized runs against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_plic_claim_arbiter;

  localparam int N      = 8;
  localparam int LAT    = 2 * (N + 1) + 1;
  localparam int SETTLE = LAT + 3;
  localparam logic [31:0] SRC_MASK = 32'h0000_01FE;
`ifdef PLIC_EDGE_TRIGGER_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] global_interrupts = '0;
  logic        prio_wr_en = 1'b0;
  logic [4:0]  prio_wr_id = '0;
  logic [4:0]  prio_wr_data = '0;
  logic [31:0] enable_mask = '0;
  logic [4:0]  threshold = '0;
  logic        claim_req = 1'b0;
  logic        claim_valid;
  logic [4:0]  claim_id;
  logic        complete_req = 1'b0;
  logic [4:0]  complete_id = '0;
  logic [31:0] interrupt_pending;
  logic        irq_out;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pend, m_infl, m_prev;
  int          m_prio [0:31];

  plic_claim_arbiter #(
    .INTERRUPTS     (N),
    .PRIORITY_LEVELS(32),
    .PRIO_W         (5),
    .ID_W           (5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .global_interrupts(global_interrupts),
    .prio_wr_en       (prio_wr_en),
    .prio_wr_id       (prio_wr_id),
    .prio_wr_data     (prio_wr_data),
    .enable_mask      (enable_mask),
    .threshold        (threshold),
    .claim_req        (claim_req),
    .claim_valid      (claim_valid),
    .claim_id         (claim_id),
    .complete_req     (complete_req),
    .complete_id      (complete_id),
    .interrupt_pending(interrupt_pending),
    .irq_out          (irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int          id_a;
    int          prio_a;
    int          id_b;
    int          prio_b;
    int          thr;
    logic [31:0] en;
    logic [31:0] lines;
    logic [31:0] exp_pend;
    bit          exp_irq;
    int          exp_id;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    global_interrupts = '0;
    enable_mask       = '0;
    threshold         = '0;
    prio_wr_en        = 1'b0;
    prio_wr_id        = '0;
    prio_wr_data      = '0;
    claim_req         = 1'b0;
    complete_req      = 1'b0;
    complete_id       = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_prio(input int id, input int data);
    prio_wr_en   = 1'b1;
    prio_wr_id   = 5'(id);
    prio_wr_data = 5'(data);
    tick();
    prio_wr_en = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete_req = 1'b1;
    complete_id  = 5'(id);
    tick();
    complete_req = 1'b0;
    complete_id  = '0;
  endtask

  task automatic do_claim(input string name, input int exp_id);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check({name, "_valid"}, 32'(claim_valid), 32'd1);
    check({name, "_id"}, 32'(claim_id), 32'(exp_id));
  endtask

  function automatic bit qualifies(input int i);
    return m_pend[i] && enable_mask[i] && (m_prio[i] > int'(threshold));
  endfunction

  // Highest qualifying priority first, then the lowest ID holding it.
  function automatic int model_best();
    int top = 0;
    for (int i = 1; i <= N; i++)
      if (qualifies(i) && m_prio[i] > top) top = m_prio[i];
    if (top == 0) return 0;
    for (int i = 1; i <= N; i++)
      if (qualifies(i) && m_prio[i] == top) return i;
    return 0;
  endfunction

  initial begin
    vecs[0] = '{"src3_basic",  3, 5, 0, 0, 0, 32'h08,       32'h08,  32'h08, 1'b1, 3};
    vecs[1] = '{"tie_2_5",     2, 7, 5, 7, 0, 32'h24,       32'h24,  32'h24, 1'b1, 2};
    vecs[2] = '{"thr_equal",   4, 4, 0, 0, 4, 32'h10,       32'h10,  32'h10, 1'b0, 0};
    vecs[3] = '{"thr_below",   4, 4, 0, 0, 3, 32'h10,       32'h10,  32'h10, 1'b1, 4};
    vecs[4] = '{"disabled",    6, 9, 0, 0, 0, 32'h00,       32'h40,  32'h40, 1'b0, 0};
    vecs[5] = '{"higher_wins", 1, 2, 7, 9, 1, 32'h82,       32'h82,  32'h82, 1'b1, 7};
    vecs[6] = '{"prio_zero",   2, 0, 0, 0, 0, 32'h04,       32'h04,  32'h04, 1'b0, 0};
    vecs[7] = '{"bad_ids",     9, 5, 0, 0, 0, 32'hFFFFFFFF, 32'h201, 32'h00, 1'b0, 0};

    // ---------------- reset with toggling inputs ----------------
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      global_interrupts = $urandom;
      enable_mask       = $urandom;
      threshold         = 5'($urandom);
      prio_wr_en        = 1'b1;
      prio_wr_id        = 5'($urandom_range(1, N));
      prio_wr_data      = 5'($urandom);
      claim_req         = 1'b1;
      complete_req      = 1'b1;
      complete_id       = 5'($urandom);
      tick();
      check("reset_outputs", {25'd0, claim_valid, claim_id, irq_out}, 32'd0);
      check("reset_pending", interrupt_pending, 32'd0);
    end
    global_interrupts = '0;
    enable_mask       = '0;
    threshold         = '0;
    prio_wr_en        = 1'b0;
    claim_req         = 1'b0;
    complete_req      = 1'b0;
    rst_n             = 1'b1;
    begin
      bit seen = 1'b0;
      repeat (30) begin
        tick();
        seen |= irq_out;
      end
      check("idle_irq_quiet", 32'(seen), 32'd0);
    end

    // ---------------- vector table ----------------
    for (int v = 0; v < 8; v++) begin
      do_reset();
      write_prio(vecs[v].id_a, vecs[v].prio_a);
      write_prio(vecs[v].id_b, vecs[v].prio_b);
      enable_mask       = vecs[v].en;
      threshold         = 5'(vecs[v].thr);
      global_interrupts = vecs[v].lines;
      repeat (SETTLE) tick();
      check({vecs[v].name, "_irq"}, 32'(irq_out), 32'(vecs[v].exp_irq));
      check({vecs[v].name, "_pend"}, interrupt_pending, vecs[v].exp_pend);
      do_claim(vecs[v].name, vecs[v].exp_id);
      check({vecs[v].name, "_pend_after"}, interrupt_pending,
            vecs[v].exp_pend & ~((vecs[v].exp_id != 0) ? (32'h1 << vecs[v].exp_id) : 32'h0));
      check({vecs[v].name, "_irq_after"}, 32'(irq_out),
            (vecs[v].exp_id != 0) ? 32'd0 : 32'(vecs[v].exp_irq));
    end

    // ---------------- source-to-irq latency bound ----------------
    do_reset();
    write_prio(3, 5);
    enable_mask = 32'h08;
    global_interrupts = 32'h08;
    begin
      int k = 0;
      while (irq_out !== 1'b1 && k < LAT) begin
        tick();
        k++;
      end
      check("irq_latency_bound", 32'(irq_out), 32'd1);
    end
    do_claim("lat_claim", 3);
    check("lat_irq_cleared", 32'(irq_out), 32'd0);
    tick();
    check("claim_valid_pulse", 32'(claim_valid), 32'd0);

    // ---------------- tie: two claims without complete ----------------
    do_reset();
    write_prio(2, 7);
    write_prio(5, 7);
    enable_mask = 32'h24;
    global_interrupts = 32'h24;
    repeat (SETTLE) tick();
    do_claim("tie_first", 2);
    repeat (SETTLE) tick();
    check("tie_irq_again", 32'(irq_out), 32'd1);
    do_claim("tie_second", 5);
    check("tie_pend_empty", interrupt_pending, 32'd0);

    // ---------------- empty claim, ignored completes, claim+complete ----------------
    do_reset();
    do_claim("empty", 0);
    check("empty_pend", interrupt_pending, 32'd0);
    write_prio(2, 3);
    enable_mask = 32'h04;
    global_interrupts = 32'h04;
    repeat (SETTLE) tick();
    do_claim("src2", 2);
    do_complete(0);
    check("complete_id0_ignored", interrupt_pending, 32'd0);
    do_complete(9);
    check("complete_id9_ignored", interrupt_pending, 32'd0);
    do_complete(3);
    check("complete_notinflight_ignored", interrupt_pending, 32'd0);
    write_prio(5, 6);
    enable_mask = 32'h24;
    global_interrupts = 32'h24;
    repeat (SETTLE) tick();
    check("src5_pend", interrupt_pending, 32'h20);
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 5'd2;
    tick();
    claim_req    = 1'b0;
    complete_req = 1'b0;
    check("simul_claim_id", 32'(claim_id), 32'd5);
    check("simul_pend", interrupt_pending, EDGE ? 32'h0 : 32'h04);

    // ---------------- source held high across complete ----------------
    do_reset();
    write_prio(1, 3);
    enable_mask = 32'h02;
    global_interrupts = 32'h02;
    repeat (SETTLE) tick();
    do_claim("hold1", 1);
    tick();
    check("hold1_pend_inflight", interrupt_pending, 32'h0);
    do_complete(1);
    check("hold1_pend_after_complete", interrupt_pending, EDGE ? 32'h0 : 32'h02);
    global_interrupts = 32'h0;
    tick();
    global_interrupts = 32'h02;
    tick();
    check("hold1_pend_after_toggle", interrupt_pending, 32'h02);

    // ---------------- randomized against reference model ----------------
    do_reset();
    m_pend = '0;
    m_infl = '0;
    m_prev = '0;
    for (int i = 0; i < 32; i++) m_prio[i] = 0;
    for (int it = 0; it < 40; it++) begin
      int          nc;
      int          np;
      int          exp_id;
      logic [31:0] newl;
      nc = $urandom_range(0, 2);
      for (int k = 0; k < nc; k++) begin
        int id = $urandom_range(0, 10);
        do_complete(id);
        if (id >= 1 && id <= N) m_infl[id] = 1'b0;
        if (!EDGE) m_pend |= m_prev & SRC_MASK & ~m_infl;
      end
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) begin
        int id = $urandom_range(0, 10);
        int pv = $urandom_range(0, 31);
        write_prio(id, pv);
        if (id >= 1 && id <= N) m_prio[id] = pv;
      end
      enable_mask = $urandom;
      threshold   = 5'($urandom_range(0, 6));
      newl        = $urandom;
      if (EDGE) m_pend |= newl & ~m_prev & SRC_MASK & ~m_infl;
      else      m_pend |= newl & SRC_MASK & ~m_infl;
      m_prev = newl;
      global_interrupts = newl;
      repeat (SETTLE) tick();
      exp_id = model_best();
      check("rand_irq", 32'(irq_out), (exp_id != 0) ? 32'd1 : 32'd0);
      check("rand_pend", interrupt_pending, m_pend);
      do_claim("rand_claim", exp_id);
      if (exp_id != 0) begin
        m_pend[exp_id] = 1'b0;
        m_infl[exp_id] = 1'b1;
      end
      check("rand_pend_after", interrupt_pending, m_pend);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
